// File: rtl/key_pkg.sv
// Shared constants and state encoding for the key debouncer.
// The optional long-press detector is enabled by KEY_DEBOUNCE_LONG_PRESS_EN.
package key_pkg;

  localparam logic [1:0] UP      = 2'd0;
  localparam logic [1:0] FILT_DN = 2'd1;
  localparam logic [1:0] DOWN    = 2'd2;
  localparam logic [1:0] FILT_UP = 2'd3;

  typedef enum logic [1:0] {
    StUp     = UP,
    StFiltDn = FILT_DN,
    StDown   = DOWN,
    StFiltUp = FILT_UP
  } key_state_e;

  localparam logic KEY_IDLE_LEVEL = 1'b1;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int unsigned LONG_CYCLES_DEFAULT     = 50_000_000;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops load RESET_VAL on synchronous reset.
module key_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_q = r_sync2;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for an active-low mechanical key: synchronise, filter, emit level and strobes.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to build the long-press hold detector.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_out,
  output logic key_press,
  output logic key_release,
  output logic long_press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 2) begin : g_chk_long
    $error("LONG_CYCLES must be at least 2");
  end

  logic            w_key_s;
  logic            w_press_acc;
  logic            w_release_acc;
  key_state_e      r_state;
  logic [CntW-1:0] r_cnt;

  key_sync #(
    .RESET_VAL (KEY_IDLE_LEVEL)
  ) u_key_sync (
    .clk (clk),
    .rst (rst),
    .i_d (key_in),
    .o_q (w_key_s)
  );

  assign w_press_acc   = (r_state == StFiltDn) && !w_key_s && (r_cnt == CntLast);
  assign w_release_acc = (r_state == StFiltUp) &&  w_key_s && (r_cnt == CntLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StUp;
      r_cnt       <= '0;
      key_out     <= KEY_IDLE_LEVEL;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      unique case (r_state)
        StUp: begin
          if (!w_key_s) begin
            r_state <= StFiltDn;
            r_cnt   <= CntW'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        StFiltDn: begin
          // Any high sample abandons the candidate press and restarts from UP.
          if (w_key_s) begin
            r_state <= StUp;
            r_cnt   <= '0;
          end else if (r_cnt == CntLast) begin
            r_state   <= StDown;
            key_out   <= 1'b0;
            key_press <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDown: begin
          if (w_key_s) begin
            r_state <= StFiltUp;
            r_cnt   <= CntW'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        StFiltUp: begin
          if (!w_key_s) begin
            r_state <= StDown;
            r_cnt   <= '0;
          end else if (r_cnt == CntLast) begin
            r_state     <= StUp;
            key_out     <= 1'b1;
            key_release <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state <= StUp;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic [HoldW-1:0] r_hold;
  logic             r_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold     <= '0;
      r_armed    <= 1'b1;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (w_press_acc) begin
        r_hold <= '0;
      end else if ((r_state == StDown || r_state == StFiltUp) && r_armed) begin
        if (r_hold == HoldLast) begin
          long_press <= 1'b1;
          r_armed    <= 1'b0;
        end else begin
          r_hold <= r_hold + HoldW'(1);
        end
      end
      // Only an accepted release re-arms, so one hold yields one strobe.
      if (w_release_acc) begin
        r_armed <= 1'b1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused   = w_press_acc ^ w_release_acc;
  assign long_press = 1'b0;
`endif

endmodule
